data_memory_responder: RTL and testbench



---
 rtl/data_memory_responder.sv | 130 +++++++++++++
 tb/tb_data_memory_responder.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/data_memory_responder.sv
// data_memory_responder: LC3 data-memory bus responder.
// A request is captured, held for LATENCY cycles, then the read or write is
// applied to an internal 2^AW x 16 word array and complete_data pulses once.
// Optional build macro DATA_MEM_ADDR_CHECK_EN: addresses with bits above AW-1
// set are out of range; such writes are dropped, such reads return zero, and
// the sticky oor_err flag is raised. Without it, the upper bits alias.
//
// state | meaning
// IDLE  | waiting for Data_req; captures the request
// WAIT  | latency countdown; the access happens on the edge where cnt==0
// HOLD  | access done; waits for Data_req to drop before accepting another
module data_memory_responder #(
  parameter int AW      = 8,
  parameter int LATENCY = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        Data_req,
  input  logic        Data_rd,
  input  logic [15:0] Data_addr,
  input  logic [15:0] Data_din,
  output logic        complete_data,
  output logic [15:0] Data_dout,
  output logic        busy,
  output logic        oor_err
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  state_t          state;
  state_t          state_next;
  logic [3:0]      cnt;
  logic [AW-1:0]   idx_q;
  logic [15:0]     din_q;
  logic            rd_q;
  logic            oor_q;
  logic            addr_oor;
  logic            capture;
  logic            access_now;
  logic [15:0]     mem [0:(1<<AW)-1];

  assign capture    = (state == ST_IDLE) && Data_req;
  assign access_now = (state == ST_WAIT) && (cnt == 4'd0);
  assign busy       = (state != ST_IDLE);

`ifdef DATA_MEM_ADDR_CHECK_EN
  // Any set bit above the index field marks the request out of range.
  assign addr_oor = ((Data_addr >> AW) != 16'h0000);

  // Sticky error flag, raised when an out-of-range access completes.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      oor_err <= 1'b0;
    end else if (access_now && oor_q) begin
      oor_err <= 1'b1;
    end
  end
`else
  logic unused_addr_hi;

  // Upper address bits alias onto the array; they are deliberately ignored.
  assign unused_addr_hi = |(Data_addr >> AW);
  assign addr_oor       = 1'b0;
  assign oor_err        = 1'b0;
`endif

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; HOLD blocks re-triggering until Data_req goes low.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (Data_req)   state_next = ST_WAIT;
      ST_WAIT: if (access_now) state_next = ST_HOLD;
      ST_HOLD: if (!Data_req)  state_next = ST_IDLE;
      default:                 state_next = ST_IDLE;
    endcase
  end

  // Request capture and latency down-counter; bus inputs are ignored after capture.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt   <= 4'd0;
      idx_q <= '0;
      din_q <= 16'h0000;
      rd_q  <= 1'b0;
      oor_q <= 1'b0;
    end else if (capture) begin
      cnt   <= 4'(LATENCY - 1);
      idx_q <= Data_addr[AW-1:0];
      din_q <= Data_din;
      rd_q  <= Data_rd;
      oor_q <= addr_oor;
    end else if ((state == ST_WAIT) && (cnt != 4'd0)) begin
      cnt <= cnt - 4'd1;
    end
  end

  // Completion pulse and read-data register; Data_dout changes only on reads.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      complete_data <= 1'b0;
      Data_dout     <= 16'h0000;
    end else begin
      complete_data <= access_now;
      if (access_now && rd_q) begin
        Data_dout <= oor_q ? 16'h0000 : mem[idx_q];
      end
    end
  end

  // Word array write port; not reset so contents survive a reset.
  always_ff @(posedge clock) begin
    if (access_now && !rd_q && !oor_q) begin
      mem[idx_q] <= din_q;
    end
  end

endmodule

// File: tb/tb_data_memory_responder.sv
// Directed bench for data_memory_responder: one instance at LATENCY=2 for the
// protocol scenarios and one at LATENCY=1 for the full-address sweep.
module tb_data_memory_responder;

  localparam int AW   = 8;
  localparam int LAT  = 2;
  localparam int LAT1 = 1;

  logic        clock = 1'b0;
  logic        reset = 1'b1;

  logic        Data_req = 1'b0;
  logic        Data_rd = 1'b0;
  logic [15:0] Data_addr = 16'h0000;
  logic [15:0] Data_din = 16'h0000;
  logic        complete_data;
  logic [15:0] Data_dout;
  logic        busy;
  logic        oor_err;

  logic        req1 = 1'b0;
  logic        rd1 = 1'b0;
  logic [15:0] addr1 = 16'h0000;
  logic [15:0] din1 = 16'h0000;
  logic        complete1;
  logic [15:0] dout1;
  logic        busy1;
  logic        oor1;

  int tests = 0;
  int fails = 0;

  always #5 clock = ~clock;

  data_memory_responder #(.AW(AW), .LATENCY(LAT)) dut (
    .clock(clock), .reset(reset),
    .Data_req(Data_req), .Data_rd(Data_rd), .Data_addr(Data_addr), .Data_din(Data_din),
    .complete_data(complete_data), .Data_dout(Data_dout), .busy(busy), .oor_err(oor_err)
  );

  data_memory_responder #(.AW(AW), .LATENCY(LAT1)) dut1 (
    .clock(clock), .reset(reset),
    .Data_req(req1), .Data_rd(rd1), .Data_addr(addr1), .Data_din(din1),
    .complete_data(complete1), .Data_dout(dout1), .busy(busy1), .oor_err(oor1)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Called at a negedge with the LATENCY=2 responder idle; returns at a negedge with it idle.
  task automatic access(input logic rd, input logic [15:0] addr, input logic [15:0] din,
                        input int hold, input bit corrupt, output logic [15:0] dout);
    int  n;
    bit  seen;
    Data_req  = 1'b1;
    Data_rd   = rd;
    Data_addr = addr;
    Data_din  = din;
    n    = 0;
    seen = 0;
    while (!seen && n < 20) begin
      @(negedge clock);
      n++;
      if (n == 1) begin
        chk("busy_wait", {31'd0, busy}, 32'd1);
        if (corrupt) begin
          Data_addr = 16'h0011;
          Data_din  = 16'h1234;
        end
      end
      if (complete_data) seen = 1;
    end
    chk("complete_seen", {31'd0, seen}, 32'd1);
    chk("latency", n, LAT + 1);
    dout = Data_dout;
    for (int h = 0; h < hold; h++) begin
      @(negedge clock);
      chk("single_pulse", {31'd0, complete_data}, 32'd0);
      chk("busy_hold", {31'd0, busy}, 32'd1);
    end
    Data_req = 1'b0;
    @(negedge clock);
    chk("idle_after", {31'd0, busy}, 32'd0);
    chk("pulse_end", {31'd0, complete_data}, 32'd0);
  endtask

  task automatic access1(input logic rd, input logic [15:0] addr, input logic [15:0] din,
                         output logic [15:0] dout);
    int n;
    bit seen;
    req1  = 1'b1;
    rd1   = rd;
    addr1 = addr;
    din1  = din;
    n     = 0;
    seen  = 0;
    while (!seen && n < 20) begin
      @(negedge clock);
      n++;
      if (complete1) seen = 1;
    end
    chk("lat1_latency", n, LAT1 + 1);
    dout = dout1;
    req1 = 1'b0;
    @(negedge clock);
  endtask

  initial begin
    logic [15:0] d;

    // Reset values
    #1;
    chk("rst_complete", {31'd0, complete_data}, 32'd0);
    chk("rst_dout", {16'd0, Data_dout}, 32'h0000);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_oor", {31'd0, oor_err}, 32'd0);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);

    // Write then read back
    access(1'b0, 16'h0010, 16'hBEEF, 0, 0, d);
    access(1'b1, 16'h0010, 16'h0000, 0, 0, d);
    chk("read_beef", {16'd0, d}, 32'h0000BEEF);

    // Request held high after completion: one pulse only, then minimum-gap re-request
    access(1'b1, 16'h0010, 16'h0000, 6, 0, d);
    chk("held_read", {16'd0, d}, 32'h0000BEEF);

    // Bus changes during WAIT are ignored
    access(1'b0, 16'h0011, 16'h7777, 0, 0, d);
    access(1'b0, 16'h0012, 16'h5555, 0, 1, d);
    access(1'b1, 16'h0012, 16'h0000, 0, 0, d);
    chk("read_0x12", {16'd0, d}, 32'h00005555);
    access(1'b1, 16'h0011, 16'h0000, 0, 0, d);
    chk("read_0x11", {16'd0, d}, 32'h00007777);

    // Writes leave Data_dout unchanged
    access(1'b0, 16'h0020, 16'h0F0F, 0, 0, d);
    chk("dout_after_write", {16'd0, Data_dout}, 32'h00007777);
    access(1'b1, 16'h0020, 16'h0000, 0, 0, d);
    chk("read_0x20_pre", {16'd0, d}, 32'h00000F0F);

    // Reset in the middle of a write
    Data_req  = 1'b1;
    Data_rd   = 1'b0;
    Data_addr = 16'h0020;
    Data_din  = 16'hAAAA;
    @(posedge clock);
    @(posedge clock);
    #1;
    chk("mid_busy_before", {31'd0, busy}, 32'd1);
    reset    = 1'b1;
    Data_req = 1'b0;
    #1;
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    chk("mid_rst_complete", {31'd0, complete_data}, 32'd0);
    chk("mid_rst_dout", {16'd0, Data_dout}, 32'h0000);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    @(negedge clock);
    chk("post_rst_complete", {31'd0, complete_data}, 32'd0);
    access(1'b1, 16'h0020, 16'h0000, 0, 0, d);
    chk("read_0x20_kept", {16'd0, d}, 32'h00000F0F);

    // Upper address bits
    access(1'b0, 16'h0005, 16'h0505, 0, 0, d);
    chk("oor_clear_inrange", {31'd0, oor_err}, 32'd0);
    access(1'b0, 16'h0105, 16'hCAFE, 0, 0, d);
`ifdef DATA_MEM_ADDR_CHECK_EN
    chk("oor_set", {31'd0, oor_err}, 32'd1);
    access(1'b1, 16'h0005, 16'h0000, 0, 0, d);
    chk("alias_dropped", {16'd0, d}, 32'h00000505);
    access(1'b1, 16'h0105, 16'h0000, 0, 0, d);
    chk("oor_read_zero", {16'd0, d}, 32'h00000000);
    chk("oor_sticky", {31'd0, oor_err}, 32'd1);
`else
    chk("oor_tied", {31'd0, oor_err}, 32'd0);
    access(1'b1, 16'h0005, 16'h0000, 0, 0, d);
    chk("alias_read", {16'd0, d}, 32'h0000CAFE);
    access(1'b1, 16'h0105, 16'h0000, 0, 0, d);
    chk("alias_read_hi", {16'd0, d}, 32'h0000CAFE);
    chk("oor_tied2", {31'd0, oor_err}, 32'd0);
`endif
    reset = 1'b1;
    #1;
    chk("oor_after_rst", {31'd0, oor_err}, 32'd0);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);

    // LATENCY=1 sweep over every word: data = ~addr
    for (int i = 0; i < 256; i++) begin
      logic [15:0] a;
      a = 16'(i);
      access1(1'b0, a, ~a, d);
    end
    for (int i = 0; i < 256; i++) begin
      logic [15:0] a;
      a = 16'(i);
      access1(1'b1, a, 16'h0000, d);
      chk("sweep_read", {16'd0, d}, {16'd0, ~a});
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
